// File: rtl/ucode_pkg.sv
// Shared types and constants for the microcode sequencer.
// The microcode length table is kept here so the future microcode ROM
// can index the same entries.
package ucode_pkg;

  localparam int UADDR_W_DEF = 6;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } state_e;

  // Number of uops minus one for each microcode entry. Index = entry.
  localparam logic [15:0][1:0] LEN_M1_TABLE = {
    2'd3,                                   // 15
    2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,     // 14..9
    2'd2,                                   // 8
    2'd0, 2'd0, 2'd0, 2'd0,                 // 7..4
    2'd2,                                   // 3
    2'd1,                                   // 2
    2'd1,                                   // 1
    2'd0                                    // 0
  };

endpackage

// File: rtl/ucode_len_rom.sv
// Combinational 16x2 lookup: microcode entry -> uop count minus one.
module ucode_len_rom
  import ucode_pkg::*;
(
  input  logic [3:0] entry_i,
  output logic [1:0] len_m1_o
);

  assign len_m1_o = LEN_M1_TABLE[entry_i];

endmodule

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: expands each decoded instruction into 1-4 uops.
// Optional ROM-uop performance counter: define UCODE_PERF_CNT_EN.
module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter int PAYLOAD_W = 128,
  parameter int UADDR_W   = UADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_rom_in_control,
  input  logic [3:0]           in_rom_control,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_rom_active,
  output logic [UADDR_W-1:0]   out_uaddr,
  output logic                 out_first,
  output logic                 out_last,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [31:0]          perf_rom_uops
);

  state_e               state_q, state_d;
  logic                 rom_q, rom_d;
  logic [3:0]           entry_q, entry_d;
  logic [1:0]           step_q, step_d;
  logic [1:0]           len_q, len_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;

  logic [1:0] rom_len;
  logic [1:0] in_len;
  logic [1:0] step_inc;
  logic       load;
  logic       fire;

  ucode_len_rom u_len_rom (
    .entry_i  (in_rom_control),
    .len_m1_o (rom_len)
  );

  assign in_len   = in_rom_in_control ? rom_len : 2'd0;
  assign step_inc = step_q + 2'd1;

  // Handshake and output decode straight from the holding register.
  assign out_valid      = (state_q != EMPTY);
  assign fire           = out_valid && out_ready && !flush;
  assign out_last       = (state_q == SINGLE);
  assign out_first      = out_valid && (step_q == 2'd0);
  assign out_rom_active = out_valid && rom_q;
  assign out_uaddr      = out_rom_active ? UADDR_W'({entry_q, step_q}) : '0;
  assign out_payload    = payload_q;

  // in_ready depends only on state and out_ready, never on in_valid.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      EMPTY:   in_ready = 1'b1;
      SINGLE:  in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  // Next-state: advance through steps, reload on accept, flush wins.
  always_comb begin
    state_d   = state_q;
    rom_d     = rom_q;
    entry_d   = entry_q;
    step_d    = step_q;
    len_d     = len_q;
    payload_d = payload_q;
    load      = 1'b0;
    case (state_q)
      EMPTY: load = in_valid;
      SINGLE: begin
        if (out_ready) begin
          if (in_valid) load = 1'b1;
          else          state_d = EMPTY;
        end
      end
      MULTI: begin
        if (out_ready) begin
          step_d = step_inc;
          if (step_inc == len_q) state_d = SINGLE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (load) begin
      rom_d     = in_rom_in_control;
      entry_d   = in_rom_control;
      step_d    = 2'd0;
      len_d     = in_len;
      payload_d = in_payload;
      state_d   = (in_len == 2'd0) ? SINGLE : MULTI;
    end
    if (flush) begin
      state_d   = EMPTY;
      step_d    = 2'd0;
      rom_d     = rom_q;
      entry_d   = entry_q;
      len_d     = len_q;
      payload_d = payload_q;
    end
  end

  // Holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= EMPTY;
      rom_q     <= 1'b0;
      entry_q   <= 4'd0;
      step_q    <= 2'd0;
      len_q     <= 2'd0;
      payload_q <= '0;
    end else begin
      state_q   <= state_d;
      rom_q     <= rom_d;
      entry_q   <= entry_d;
      step_q    <= step_d;
      len_q     <= len_d;
      payload_q <= payload_d;
    end
  end

`ifdef UCODE_PERF_CNT_EN
  logic [31:0] perf_q;

  // Count ROM uops actually handed downstream; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       perf_q <= 32'd0;
    else if (fire && out_rom_active) perf_q <= perf_q + 32'd1;
  end

  assign perf_rom_uops = perf_q;
`else
  assign perf_rom_uops = 32'd0;
`endif

endmodule

// File: doc/ucode_sequencer.md
Name: ucode_sequencer

Overview:
- Sits directly downstream of the opcode ROM control cloud in the decode stage.
- Consumes each decoded instruction together with its ROM selection: rom_in_control (instruction is microcoded) and rom_control[3:0] (microcode entry index).
- A microcoded instruction is expanded into 1-4 sequential micro-ops with microcode ROM addresses. A non-microcoded instruction passes through as a single op.
- Back-pressures decode while a multi-uop sequence is issuing.

Parameters:
- PAYLOAD_W, 128: width of the decoded-instruction payload carried alongside each uop.
- UADDR_W, 6: microcode ROM address width; uaddr = {entry[3:0], step[1:0]}.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous pipeline flush (branch/exception redirect)
- in_valid  input  1  decode presents an instruction
- in_ready  output  1  sequencer accepts this cycle
- in_rom_in_control  input  1  instruction is microcoded
- in_rom_control  input  4  microcode entry index
- in_payload  input  PAYLOAD_W  decoded instruction fields
- out_valid  output  1  uop available
- out_ready  input  1  downstream accepts uop
- out_rom_active  output  1  uop comes from microcode ROM
- out_uaddr  output  UADDR_W  microcode ROM address (0 when out_rom_active=0)
- out_first  output  1  first uop of the instruction
- out_last  output  1  final uop of the instruction
- out_payload  output  PAYLOAD_W  held instruction payload
- perf_rom_uops  output  32  count of ROM uops issued (see optional feature)

Behaviour:
- Handshake:
  - Input transfer occurs on in_valid && in_ready.
  - Output transfer occurs on out_valid && out_ready.
  - Both are valid/ready; no combinational path from in_valid to out_valid.
- Holding register: valid, rom, entry[3:0], step[1:0], len_m1[1:0], payload.
- len_m1:
  - LEN_M1_TABLE[entry] when rom=1.
  - 0 when rom=0.
- State machine:
  - EMPTY:
    - out_valid=0, in_ready=1.
    - Accept → SINGLE if len_m1==0, else MULTI; step=0.
  - SINGLE (last uop pending):
    - out_valid=1, out_last=1.
    - in_ready = out_ready.
    - Fire with accept → reload, go to SINGLE or MULTI.
    - Fire without accept → EMPTY.
    - No fire → hold.
  - MULTI (non-last uop pending):
    - out_valid=1, out_last=0, in_ready=0.
    - Fire → step+1; go to SINGLE when step+1 == len_m1.
- Outputs:
  - out_first = (step==0).
  - out_uaddr = {entry, step} when rom, else 0.
- Latency: accepted instruction appears on out_valid the next cycle. Sustained throughput is 1 instruction/cycle for single-uop instructions.
- Outputs are stable while out_valid && !out_ready.
- flush:
  - Has priority over all transfers.
  - Next state is EMPTY; step=0; any same-cycle input is discarded.
  - in_ready is unaffected in the flush cycle.
- Reset (async) values:
  - state=EMPTY, out_valid=0, in_ready=1 (combinational from EMPTY).
  - out_uaddr=0, out_first=0, out_last=0, out_rom_active=0, out_payload=0.
  - perf_rom_uops=0.
- Reset mid-sequence abandons the sequence with no further uops.
- step never wraps: the maximum is len_m1 ≤ 3.

Optional Feature:
- Macro: UCODE_PERF_CNT_EN.
- Defined: perf_rom_uops increments by 1 on every output fire with out_rom_active=1. It wraps at 2^32, is cleared only by reset, and flush does not clear it.
- Undefined: no counter register; perf_rom_uops tied to 0.

Decomposition:
- Package ucode_pkg holds:
  - UADDR_W default.
  - State enum {EMPTY, SINGLE, MULTI}.
  - LEN_M1_TABLE[16] (2-bit each): entry 0→0, 1→1, 2→1, 3→2, 8→2, 15→3, all others→0.
- One sub-module is natural: ucode_len_rom, a combinational 16x2 lookup from entry to len_m1, reused by the future microcode ROM.

Test Plan:
- Reset: assert reset mid-MULTI (entry 8, step 1) → out_valid=0, in_ready=1, perf_rom_uops=0 immediately. No uaddr 0x22 is ever emitted.
- Pass-through: 4 back-to-back non-ROM instructions with out_ready=1 → 4 uops on consecutive cycles, each first=last=1, uaddr=0, in_ready continuously 1.
- Entry 8 (3 uops) with out_ready=1 → uaddr 0x20, 0x21, 0x22; first on 0x20 only, last on 0x22 only. in_ready low for 2 cycles; the next instruction is accepted on the 0x22 fire cycle.
- Back-pressure: entry 15 with out_ready toggling 1,0,0,1,1,1 → uaddr 0x3C..0x3F, each held stable through stall cycles, payload unchanged.
- Flush during entry 3 at step 1 with in_valid=1 in the same cycle → next cycle out_valid=0. The input is dropped; next accepted instruction starts at step 0.
- UCODE_PERF_CNT_EN: entries 8, 0 (rom=0), 15 → perf_rom_uops=7. With the macro undefined → perf_rom_uops stays 0.
